// File: rtl/wash_pkg.sv
// Shared state encodings, default phase timings and the phase-length helper
// used by the washing-machine programme sequencer.
package wash_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WASH  = 3'd2;
    localparam logic [2:0] S_RINSE = 3'd3;
    localparam logic [2:0] S_SPIN  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_FILL  = S_FILL,
        ST_WASH  = S_WASH,
        ST_RINSE = S_RINSE,
        ST_SPIN  = S_SPIN
    } state_t;

    localparam int CLK_FREQ_DEF = 4;
    localparam int T_FILL_DEF   = 2;
    localparam int T_WASH_DEF   = 5;
    localparam int T_RINSE_DEF  = 2;
    localparam int T_SPIN_DEF   = 1;

    // Phase length in clock ticks; a zero-length phase still lasts one cycle.
    function automatic logic [7:0] phase_len(input int freq, input int secs);
        logic [7:0] n;
        n = 8'(freq * secs);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/wash_cycle_ctrl_phase_timer.sv
// Per-phase tick counter: cleared on phase entry, flags the final enabled tick.
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] len,
    output logic       last
);

    logic [7:0] r_cnt;

    assign last = en && (r_cnt == (len - 8'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (clr) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine programme sequencer: FILL -> WASH -> RINSE (-> WASH -> RINSE) -> SPIN,
// with registered valve/motor outputs that switch together with the phase.
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int T_FILL   = T_FILL_DEF,
    parameter int T_WASH   = T_WASH_DEF,
    parameter int T_RINSE  = T_RINSE_DEF,
    parameter int T_SPIN   = T_SPIN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_in,
    input  logic       double_wash,
    input  logic       door_closed,
    output logic [2:0] state_out,
    output logic       water_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       busy,
    output logic       wash_done
);

    localparam logic [7:0] N_FILL  = phase_len(CLK_FREQ, T_FILL);
    localparam logic [7:0] N_WASH  = phase_len(CLK_FREQ, T_WASH);
    localparam logic [7:0] N_RINSE = phase_len(CLK_FREQ, T_RINSE);
    localparam logic [7:0] N_SPIN  = phase_len(CLK_FREQ, T_SPIN);

    state_t     r_state;
    logic       r_dbl;
    logic       r_water;
    logic       r_drain;
    logic       r_motor;
    logic       r_done;

    state_t     w_next;
    logic       w_start;
    logic       w_en;
    logic       w_clr;
    logic       w_last;
    logic [7:0] w_len;

    assign w_start = (r_state == ST_IDLE) && coin_in && door_closed;

    // An open door only pauses the spin; the other phases ignore the interlock.
    assign w_en  = (r_state != ST_IDLE) && !((r_state == ST_SPIN) && !door_closed);
    assign w_clr = (r_state == ST_IDLE) || w_last;

    always_comb begin
        w_len = 8'd1;
        case (r_state)
            ST_FILL:  w_len = N_FILL;
            ST_WASH:  w_len = N_WASH;
            ST_RINSE: w_len = N_RINSE;
            ST_SPIN:  w_len = N_SPIN;
            default:  w_len = 8'd1;
        endcase
    end

    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_en),
        .len   (w_len),
        .last  (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_FILL;
            ST_FILL:  if (w_last)  w_next = ST_WASH;
            ST_WASH:  if (w_last)  w_next = ST_RINSE;
            ST_RINSE: if (w_last)  w_next = r_dbl ? ST_WASH : ST_SPIN;
            ST_SPIN:  if (w_last)  w_next = ST_IDLE;
            default:               w_next = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they land on the same edge as state_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dbl   <= 1'b0;
            r_water <= 1'b0;
            r_drain <= 1'b0;
            r_motor <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_dbl <= double_wash;
            end else if ((r_state == ST_RINSE) && w_last) begin
                r_dbl <= 1'b0;
            end
            r_water <= (w_next == ST_FILL) || (w_next == ST_RINSE);
            r_drain <= (w_next == ST_RINSE) || (w_next == ST_SPIN);
            r_motor <= (w_next == ST_WASH) || (w_next == ST_RINSE) ||
                       ((w_next == ST_SPIN) && door_closed);
            r_done  <= (r_state == ST_SPIN) && (w_next == ST_IDLE);
        end
    end

    assign state_out   = r_state;
    assign busy        = (r_state != ST_IDLE);
    assign water_valve = r_water;
    assign drain_valve = r_drain;
    assign motor_on    = r_motor;
    assign wash_done   = r_done;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Scoreboard bench for wash_cycle_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares whenever the outputs change.
module tb_wash_cycle_ctrl;

    typedef struct {
        int         edge_n;
        logic [7:0] vec;
    } ev_t;

    // {state[2:0], water, drain, motor, busy, done}
    localparam logic [7:0] V_IDLE     = 8'b000_000_0_0;
    localparam logic [7:0] V_DONE     = 8'b000_000_0_1;
    localparam logic [7:0] V_FILL     = 8'b001_100_1_0;
    localparam logic [7:0] V_WASH     = 8'b010_001_1_0;
    localparam logic [7:0] V_RINSE    = 8'b011_111_1_0;
    localparam logic [7:0] V_SPIN     = 8'b100_011_1_0;
    localparam logic [7:0] V_SPIN_OFF = 8'b100_010_1_0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic coin_in = 1'b0;
    logic coin_p = 1'b0;
    logic double_wash = 1'b0;
    logic door_closed = 1'b1;

    logic [2:0] state_out, st_p1, st_p2;
    logic water_valve, drain_valve, motor_on, busy, wash_done;
    logic wv1, dv1, mo1, bs1, wd1, wv2, dv2, mo2, bs2, wd2;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    ev_t q[$];
    ev_t qp1[$];
    ev_t qp2[$];
    logic [7:0] prev_vec = 8'd0;
    logic [2:0] prev_p1 = 3'd0;
    logic [2:0] prev_p2 = 3'd0;
    logic [7:0] w_vec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign w_vec = {state_out, water_valve, drain_valve, motor_on, busy, wash_done};

    wash_cycle_ctrl u_dut (
        .clk(clk), .reset(reset), .coin_in(coin_in), .double_wash(double_wash),
        .door_closed(door_closed), .state_out(state_out), .water_valve(water_valve),
        .drain_valve(drain_valve), .motor_on(motor_on), .busy(busy), .wash_done(wash_done)
    );

    wash_cycle_ctrl #(.CLK_FREQ(1), .T_RINSE(0)) u_p1 (
        .clk(clk), .reset(reset), .coin_in(coin_p), .double_wash(double_wash),
        .door_closed(door_closed), .state_out(st_p1), .water_valve(wv1),
        .drain_valve(dv1), .motor_on(mo1), .busy(bs1), .wash_done(wd1)
    );

    wash_cycle_ctrl #(.CLK_FREQ(15), .T_WASH(15)) u_p2 (
        .clk(clk), .reset(reset), .coin_in(coin_p), .double_wash(double_wash),
        .door_closed(door_closed), .state_out(st_p2), .water_valve(wv2),
        .drain_valve(dv2), .motor_on(mo2), .busy(bs2), .wash_done(wd2)
    );

    task automatic push(input int which, input int e, input logic [7:0] v);
        ev_t ev;
        ev.edge_n = e;
        ev.vec = v;
        case (which)
            1:       qp1.push_back(ev);
            2:       qp2.push_back(ev);
            default: q.push_back(ev);
        endcase
    endtask

    task automatic compare_ev(input string name, ref ev_t qq[$], input logic [7:0] got);
        ev_t ev;
        n_vec++;
        if (qq.size() == 0) begin
            n_bad++;
            $display("FAIL %s unexpected output change at edge %0d: got %b, none expected",
                     name, cyc, got);
        end else begin
            ev = qq.pop_front();
            if (ev.vec !== got || ev.edge_n != cyc) begin
                n_bad++;
                $display("FAIL %s at edge %0d: got %b, required %b at edge %0d",
                         name, cyc, got, ev.vec, ev.edge_n);
            end
        end
    endtask

    always @(negedge clk) begin
        if (w_vec !== prev_vec) begin
            compare_ev("main", q, w_vec);
            prev_vec = w_vec;
        end
        if (st_p1 !== prev_p1) begin
            compare_ev("p1_state", qp1, {5'd0, st_p1});
            prev_p1 = st_p1;
        end
        if (st_p2 !== prev_p2) begin
            compare_ev("p2_state", qp2, {5'd0, st_p2});
            prev_p2 = st_p2;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic drained(input string name);
        n_vec++;
        if (q.size() != 0 || qp1.size() != 0 || qp2.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d/%0d/%0d expected events never seen, required 0",
                     name, q.size(), qp1.size(), qp2.size());
            q.delete();
            qp1.delete();
            qp2.delete();
        end
    endtask

    task automatic go_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic push_single(input int e0);
        push(0, e0,      V_FILL);
        push(0, e0 + 8,  V_WASH);
        push(0, e0 + 28, V_RINSE);
        push(0, e0 + 36, V_SPIN);
        push(0, e0 + 40, V_DONE);
    endtask

    initial begin
        int e0;
        int e1;
        #2;
        chk("reset_outputs", w_vec, V_IDLE);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("after_release", w_vec, V_IDLE);

        // single programme; double_wash raised mid-run must not add a second wash
        e0 = cyc + 1;
        coin_in = 1'b1;
        push_single(e0);
        push(0, e0 + 41, V_IDLE);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 10);
        double_wash = 1'b1;
        go_to(e0 + 44);
        double_wash = 1'b0;
        drained("single_programme");

        // double wash, option toggled mid-run
        e0 = cyc + 1;
        coin_in = 1'b1;
        double_wash = 1'b1;
        push(0, e0,      V_FILL);
        push(0, e0 + 8,  V_WASH);
        push(0, e0 + 28, V_RINSE);
        push(0, e0 + 36, V_WASH);
        push(0, e0 + 56, V_RINSE);
        push(0, e0 + 64, V_SPIN);
        push(0, e0 + 68, V_DONE);
        push(0, e0 + 69, V_IDLE);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 15);
        double_wash = 1'b0;
        go_to(e0 + 45);
        double_wash = 1'b1;
        go_to(e0 + 72);
        double_wash = 1'b0;
        drained("double_wash");

        // door open for three edges during SPIN pauses the drum and the count
        e0 = cyc + 1;
        coin_in = 1'b1;
        push(0, e0,      V_FILL);
        push(0, e0 + 8,  V_WASH);
        push(0, e0 + 28, V_RINSE);
        push(0, e0 + 36, V_SPIN);
        push(0, e0 + 37, V_SPIN_OFF);
        push(0, e0 + 40, V_SPIN);
        push(0, e0 + 43, V_DONE);
        push(0, e0 + 44, V_IDLE);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 36);
        door_closed = 1'b0;
        go_to(e0 + 39);
        door_closed = 1'b1;
        go_to(e0 + 46);
        drained("door_open_spin");

        // door open and a stray coin during WASH change nothing
        e0 = cyc + 1;
        coin_in = 1'b1;
        push_single(e0);
        push(0, e0 + 41, V_IDLE);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 9);
        door_closed = 1'b0;
        go_to(e0 + 14);
        door_closed = 1'b1;
        go_to(e0 + 19);
        coin_in = 1'b1;
        go_to(e0 + 20);
        coin_in = 1'b0;
        go_to(e0 + 43);
        drained("wash_door_coin");

        // coin with the door open in IDLE is dropped
        door_closed = 1'b0;
        coin_in = 1'b1;
        @(negedge clk);
        coin_in = 1'b0;
        door_closed = 1'b1;
        chk("coin_door_open", {state_out, busy}, 4'b000_0);
        repeat (3) @(negedge clk);
        drained("coin_door_open_quiet");

        // coin in the wash_done cycle restarts immediately
        e0 = cyc + 1;
        coin_in = 1'b1;
        push_single(e0);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 40);
        coin_in = 1'b1;
        e1 = e0 + 41;
        push_single(e1);
        push(0, e1 + 41, V_IDLE);
        go_to(e1);
        coin_in = 1'b0;
        go_to(e1 + 43);
        drained("back_to_back");

        // asynchronous reset mid-WASH, then a clean restart
        e0 = cyc + 1;
        coin_in = 1'b1;
        push(0, e0,     V_FILL);
        push(0, e0 + 8, V_WASH);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 12);
        #2;
        reset = 1'b1;
        q.delete();
        push(0, cyc + 1, V_IDLE);
        #1;
        chk("async_reset_immediate", w_vec, V_IDLE);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("cycle_after_reset", w_vec, V_IDLE);
        e0 = cyc + 1;
        coin_in = 1'b1;
        push_single(e0);
        push(0, e0 + 41, V_IDLE);
        go_to(e0);
        coin_in = 1'b0;
        go_to(e0 + 43);
        drained("restart_after_reset");

        // parameterised instances: zero-second RINSE and a 225-cycle WASH
        e0 = cyc + 1;
        coin_p = 1'b1;
        push(1, e0,     8'd1);
        push(1, e0 + 2, 8'd2);
        push(1, e0 + 7, 8'd3);
        push(1, e0 + 8, 8'd4);
        push(1, e0 + 9, 8'd0);
        push(2, e0,       8'd1);
        push(2, e0 + 30,  8'd2);
        push(2, e0 + 255, 8'd3);
        push(2, e0 + 285, 8'd4);
        push(2, e0 + 300, 8'd0);
        go_to(e0);
        coin_p = 1'b0;
        go_to(e0 + 303);
        drained("param_instances");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
